// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides. Eight ops at width W, enable gate, result
// zero-extended to OUT_W.
// Optional feature: define LOGIC_UNIT_PIPE_ACC_EN to add an accumulator that
// can replace operand B (acc_sel) so ops chain back-to-back.
module logic_unit_pipe #(
  parameter int W     = 4,
  parameter int OUT_W = 2 * W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  logic         s1_valid, s2_valid;
  logic [W-1:0] s1_r, s2_r;
  logic         zero_q, parity_q;
  logic [W-1:0] b_eff, r;
  logic         accept, s2_load, s2_release;

  // Stage 1 can take a beat unless both stages are full and stage 2 is stuck.
  assign in_ready   = !s1_valid || !s2_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign s2_release = s2_valid && out_ready;
  // Stage 1 advances when stage 2 is empty or emptying on the same edge.
  assign s2_load    = s1_valid && (!s2_valid || out_ready);

`ifdef LOGIC_UNIT_PIPE_ACC_EN
  logic [W-1:0] acc;

  // Accumulator tracks the result of every accepted beat, gated ones included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (accept) acc <= r;
  end

  assign b_eff = acc_sel ? acc : b;
`else
  // No accumulator: acc_sel is kept on the port list only for pin compatibility.
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
  assign b_eff          = b;
`endif

  // Operation decode; en = 0 forces an all-zero result regardless of op.
  always_comb begin
    r = '0;
    case (op)
      3'b000: r = a & b_eff;
      3'b001: r = a | b_eff;
      3'b010: r = a ^ b_eff;
      3'b011: r = ~(a & b_eff);
      3'b100: r = ~(a | b_eff);
      3'b101: r = ~(a ^ b_eff);
      3'b110: r = a;
      3'b111: r = ~a;
      default: r = '0;
    endcase
    if (!en) r = '0;
  end

  // Stage 1 register: captures the computed result on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_r     <= r;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: result plus zero/parity flags, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_r     <= s1_r;
      zero_q   <= (s1_r == '0);
      parity_q <= ^s1_r;
    end else if (s2_release) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out       = OUT_W'(s2_r);
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign busy      = s1_valid || s2_valid;

endmodule
